// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-line instruction cache
// Hits answer in one cycle; misses issue a single word read to mem_ctrl and fill the line.
module icache_direct #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_enable,
  input  logic [31:0] mem_inst
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];
  logic [31:2]           miss_pc_q;

  logic [INDEX_BITS-1:0] fetch_idx, miss_idx;
  logic [TAG_BITS-1:0]   fetch_tag, miss_tag;
  logic                  hit, accept;
  logic                  do_hit, do_issue, do_fill, do_fwd;
  logic                  unused_pc_bits;

  assign fetch_idx      = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag      = fetch_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign miss_idx       = miss_pc_q[INDEX_BITS+1:2];
  assign miss_tag       = miss_pc_q[ADDR_BITS-1:INDEX_BITS+2];
  assign unused_pc_bits = ^fetch_pc[1:0];

  assign hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign fetch_ready = (state_q == IDLE);
  assign accept      = fetch_valid && fetch_ready && !flush;

  always_comb begin
    state_d  = state_q;
    do_hit   = 1'b0;
    do_issue = 1'b0;
    do_fill  = 1'b0;
    do_fwd   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            do_hit = 1'b1;
          end else begin
            do_issue = 1'b1;
            state_d  = MISS;
          end
        end
      end
      MISS: begin
        // A flushed fetch still keeps a returning word: it is correct for its address.
        if (flush) begin
          do_fill = mem_enable;
          state_d = IDLE;
        end else if (mem_enable) begin
          do_fill = 1'b1;
          do_fwd  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_pc_q  <= '0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      inst_pc    <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      inst_valid <= do_hit || do_fwd;
      if (do_hit) begin
        inst_out <= data_q[fetch_idx];
        inst_pc  <= {fetch_pc[31:2], 2'b00};
      end
      if (do_fwd) begin
        inst_out <= mem_inst;
        inst_pc  <= {miss_pc_q, 2'b00};
      end
      if (do_issue) begin
        mem_valid <= 1'b1;
        mem_addr  <= {fetch_pc[31:2], 2'b00};
        miss_pc_q <= fetch_pc[31:2];
      end
      if (state_q == MISS && state_d == IDLE) begin
        mem_valid <= 1'b0;
      end
      if (do_fill) begin
        valid_q[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (rst && rdy && do_fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_inst;
    end
  end

endmodule
